// File: rtl/psum_readout.sv
// Drain-side reader for systolic-array accumulators: captures one vector of partial
// sums, requantizes each lane (rounding shift + saturation) and streams lanes out one per beat.
module psum_readout #(
    parameter int NUM_COLS    = 4,
    parameter int IN_WIDTH    = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_COLS*IN_WIDTH-1:0] in_data,
    input  logic [SHIFT_WIDTH-1:0]       shift,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_last,
    output logic                         out_sat,
    output logic                         busy,
    output logic [15:0]                  sat_count
);

    localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH:0] SAT_MIN = -SAT_MAX - 1;

    logic [0:0]             r_state;
    logic [IN_WIDTH-1:0]    r_lanes [NUM_COLS];
    logic [SHIFT_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]       r_idx;
    logic [OUT_WIDTH-1:0]   r_out_data;
    logic                   r_out_last;
    logic                   r_out_sat;
    logic [15:0]            r_sat_count;

    logic                   w_idle;
    logic [SHIFT_WIDTH-1:0] w_in_shift;
    logic [IDX_W-1:0]       w_next_idx;
    logic [IN_WIDTH-1:0]    w_sel_lane;
    logic [SHIFT_WIDTH-1:0] w_sel_shift;
    logic [OUT_WIDTH:0]     w_q;

    // Returns {clipped, value}; one extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic [OUT_WIDTH:0] requant(input logic [IN_WIDTH-1:0]    x,
                                                   input logic [SHIFT_WIDTH-1:0] s);
        logic signed [IN_WIDTH:0] v_sum;
        logic signed [IN_WIDTH:0] v_y;
        // NOTE: blocking assignments are correct here; these are function-local temporaries.
        v_sum = $signed({x[IN_WIDTH-1], x});
        if (s != '0)
            v_sum = v_sum + ((IN_WIDTH+1)'(1) << (s - 1'b1));
        v_y = v_sum >>> s;
        if (v_y > SAT_MAX)
            return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
        else if (v_y < SAT_MIN)
            return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
        else
            return {1'b0, v_y[OUT_WIDTH-1:0]};
    endfunction

    assign w_idle     = (r_state == ST_IDLE);
    assign w_next_idx = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_in_shift = shift;
        if (int'(shift) > IN_WIDTH - 1)
            w_in_shift = SHIFT_WIDTH'(IN_WIDTH - 1);
    end

    // Lane 0 comes straight from the input at capture; later lanes from the stored vector.
    assign w_sel_lane  = w_idle ? in_data[0 +: IN_WIDTH] : r_lanes[w_next_idx];
    assign w_sel_shift = w_idle ? w_in_shift : r_shift;
    assign w_q         = requant(w_sel_lane, w_sel_shift);

    // NOTE: lane storage carries no reset; it is only read while the state says it is valid.
    always_ff @(posedge clk) begin
        if (w_idle && in_valid) begin
            for (int i = 0; i < NUM_COLS; i++)
                r_lanes[i] <= in_data[i*IN_WIDTH +: IN_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
            r_sat_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state    <= ST_DRAIN;
                        r_shift    <= w_in_shift;
                        r_idx      <= '0;
                        r_out_data <= w_q[OUT_WIDTH-1:0];
                        r_out_sat  <= w_q[OUT_WIDTH];
                        r_out_last <= (LAST_IDX == '0);
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (r_out_sat && (r_sat_count != 16'hFFFF))
                            r_sat_count <= r_sat_count + 16'd1;
                        if (r_idx == LAST_IDX) begin
                            r_state    <= ST_IDLE;
                            r_out_last <= 1'b0;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_out_data <= w_q[OUT_WIDTH-1:0];
                            r_out_sat  <= w_q[OUT_WIDTH];
                            r_out_last <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready  = w_idle;
    assign busy      = ~w_idle;
    assign out_valid = ~w_idle;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_sat   = r_out_sat;
    assign sat_count = r_sat_count;

endmodule
